// File: rtl/block_serial_subtractor_pkg.sv
// Shared types and constants for the block-serial subtractor.
// The optional overflow output is enabled by defining BLOCK_SERIAL_SUBTRACTOR_OVF_EN.
package block_serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEF = 32;
   localparam int BLOCK_DEF = 4;
   localparam int NBLK_DEF  = WIDTH_DEF / BLOCK_DEF;

   // Slice counter width; never below one bit so the counter stays declarable.
   function automatic int cnt_width(input int nblk);
      return (nblk > 1) ? $clog2(nblk) : 1;
   endfunction

   localparam int CNT_W_DEF = cnt_width(NBLK_DEF);

endpackage

// File: rtl/block_serial_subtractor_if.sv
// Operand/result channels of the block-serial subtractor.
// Ovf exists only when BLOCK_SERIAL_SUBTRACTOR_OVF_EN is defined.
interface block_serial_subtractor_if #(
   parameter int WIDTH = block_serial_subtractor_pkg::WIDTH_DEF
);
   // Both channels: a transfer happens on a rising clk edge where valid && ready.
   // The source holds valid and its payload steady until that edge; ready may
   // change freely and never depends combinationally on valid.
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
`ifdef BLOCK_SERIAL_SUBTRACTOR_OVF_EN
   logic             Ovf;

   modport master (
      output in_valid, A, B, Bin, out_ready,
      input  in_ready, out_valid, Diff, Bout, Ovf
   );

   modport slave (
      input  in_valid, A, B, Bin, out_ready,
      output in_ready, out_valid, Diff, Bout, Ovf
   );
`else
   modport master (
      output in_valid, A, B, Bin, out_ready,
      input  in_ready, out_valid, Diff, Bout
   );

   modport slave (
      input  in_valid, A, B, Bin, out_ready,
      output in_ready, out_valid, Diff, Bout
   );
`endif

endinterface

// File: rtl/block_serial_subtractor_sub_skip_block.sv
// One BLOCK-bit ripple-borrow slice with a skip mux: when every bit propagates,
// the slice borrow-out is taken straight from the borrow-in.
module sub_skip_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             bin,
   output logic [BLOCK-1:0] d,
   output logic             bout
);

   logic [BLOCK:0]   chain;
   logic [BLOCK-1:0] prop;

   always_comb begin
      chain    = '0;
      prop     = '0;
      d        = '0;
      chain[0] = bin;
      for (int i = 0; i < BLOCK; i++) begin
         prop[i]      = ~(a[i] ^ b[i]);
         d[i]         = a[i] ^ b[i] ^ chain[i];
         // generate when a=0,b=1; otherwise pass the incoming borrow on a match
         chain[i + 1] = (~a[i] & b[i]) | (prop[i] & chain[i]);
      end
      bout = (&prop) ? bin : chain[BLOCK];
   end

endmodule

// File: rtl/block_serial_subtractor.sv
// Multi-cycle A - B - Bin, one BLOCK-bit slice per clock, LSB slice first.
// Optional Ovf output enabled by defining BLOCK_SERIAL_SUBTRACTOR_OVF_EN.
module block_serial_subtractor
   import block_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int BLOCK = BLOCK_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   block_serial_subtractor_if.slave  bus,
   output state_t                    state_dbg
);

   // Requires WIDTH an integer multiple of BLOCK with at least two slices.
   localparam int NBLK  = WIDTH / BLOCK;
   localparam int CNT_W = cnt_width(NBLK);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBLK - 1);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             borrow_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             in_ready_c;
   logic             out_valid_c;
   logic             accept;
   logic             last_slice;
   logic [BLOCK-1:0] slice_d;
   logic             slice_bout;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_d = RUN;
         end
         RUN: begin
            if (cnt_q == LAST_CNT) state_d = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept     = (state_q == IDLE) && bus.in_valid;
   assign last_slice = (state_q == RUN) && (cnt_q == LAST_CNT);

   // ---------------- slice datapath ----------------
   // Operands shift right each cycle so the active slice always sits in the LSBs;
   // difference bits shift in from the top and land aligned after NBLK steps.
   sub_skip_block #(.BLOCK(BLOCK)) u_slice (
      .a    (a_q[BLOCK-1:0]),
      .b    (b_q[BLOCK-1:0]),
      .bin  (borrow_q),
      .d    (slice_d),
      .bout (slice_bout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else if (accept) begin
         cnt_q    <= '0;
         a_q      <= bus.A;
         b_q      <= bus.B;
         borrow_q <= bus.Bin;
      end else if (state_q == RUN) begin
         cnt_q    <= cnt_q + 1'b1;
         a_q      <= a_q >> BLOCK;
         b_q      <= b_q >> BLOCK;
         borrow_q <= slice_bout;
         diff_q   <= {slice_d, diff_q[WIDTH-1:BLOCK]};
         if (last_slice) bout_q <= slice_bout;
      end
   end

`ifdef BLOCK_SERIAL_SUBTRACTOR_OVF_EN
   logic ovf_q;

   // On the last slice the LSBs of a_q/b_q hold the original operand MSBs.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (last_slice) begin
         ovf_q <= (a_q[BLOCK-1] != b_q[BLOCK-1]) && (slice_d[BLOCK-1] != a_q[BLOCK-1]);
      end
   end

   assign bus.Ovf = ovf_q;
`endif

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.Diff      = diff_q;
   assign bus.Bout      = bout_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Scoreboard bench for block_serial_subtractor: randomized and directed operands
// against an arithmetic reference; Ovf also checked under BLOCK_SERIAL_SUBTRACTOR_OVF_EN.
module tb_block_serial_subtractor;
   import block_serial_subtractor_pkg::*;

   localparam int W     = 32;
   localparam int EXP_W = W + 2;

   logic   clk;
   logic   rst;
   state_t state_dbg;
   logic   hold_low;
   int     chk_cnt;
   int     pass_cnt;
   logic [EXP_W-1:0] exp_q[$];

   block_serial_subtractor_if #(.WIDTH(W)) bus ();

   block_serial_subtractor #(.WIDTH(W), .BLOCK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Returns {ovf, bout, diff}.
   function automatic logic [EXP_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic bin);
      logic [W:0] u;
      longint     s;
      logic       ovf;
      u   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
      s   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      return {ovf, u[W], u[W-1:0]};
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic timeout_fail(input string name);
      chk_cnt++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // ---------------- drivers ----------------
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input bit push);
      int guard;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.A        = a;
      bus.B        = b;
      bus.Bin      = bin;
      guard        = 0;
      while (!bus.in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         timeout_fail("accept");
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) exp_q.push_back(model(a, b, bin));
      #1;
      bus.in_valid = 1'b0;
      // scramble operands while busy; they must not affect the result
      bus.A        = $urandom;
      bus.B        = $urandom;
      bus.Bin      = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (hold_low) bus.out_ready = 1'b0;
      else          bus.out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [EXP_W-1:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               timeout_fail("unexpected_result");
            end else begin
               e = exp_q.pop_front();
               check("diff", 64'(bus.Diff), 64'(e[W-1:0]));
               check("bout", 64'(bus.Bout), 64'(e[W]));
`ifdef BLOCK_SERIAL_SUBTRACTOR_OVF_EN
               check("ovf", 64'(bus.Ovf), 64'(e[W+1]));
`endif
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int               n;
      logic [W-1:0]     a;
      logic [W-1:0]     b;
      logic             bin;
      logic [EXP_W-1:0] e;

      chk_cnt      = 0;
      pass_cnt     = 0;
      hold_low     = 1'b1;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.A        = '0;
      bus.B        = '0;
      bus.Bin      = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_diff_bout", {31'd0, bus.Bout, bus.Diff}, 64'd0);
      check("reset_state", 64'(state_dbg), 64'(IDLE));
      @(negedge clk);
      rst      = 1'b0;
      hold_low = 1'b0;

      // latency: out_valid visible NBLK edges after the accept edge
      issue(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.out_valid && n < 50);
      check("latency", 64'(n), 64'd8);
      drain();

      issue(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
      issue(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b1);
      issue(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1);
      issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
      drain();

      // back-pressure: results held while out_ready stays low
      hold_low = 1'b1;
      issue(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1);
      e = model(32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.out_valid && n < 50);
      if (n >= 50) timeout_fail("backpressure_valid");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #2;
         check("backpressure_hold", {29'd0, bus.in_ready, bus.out_valid, bus.Bout, bus.Diff},
               {29'd0, 1'b0, 1'b1, e[W], e[W-1:0]});
      end
      hold_low = 1'b0;
      drain();
      issue(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b1);
      drain();

      // reset mid-operation drops the partial result
      hold_low = 1'b1;
      issue(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_diff", 64'(bus.Diff), 64'd0);
      check("midrst_state", 64'(state_dbg), 64'(IDLE));
      @(negedge clk);
      rst      = 1'b0;
      hold_low = 1'b0;
      issue(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b1);
      drain();

      // randomized operands with a bias toward equal and boundary values
      for (int i = 0; i < 40; i++) begin
         a   = $urandom;
         b   = $urandom;
         bin = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: b = a;
            1: a = '0;
            2: b = '1;
            3: a = {1'b1, {(W-1){1'b0}}};
            default: ;
         endcase
         issue(a, b, bin, 1'b1);
      end
      drain();

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
